if_prefetch_unit: RTL and testbench

Instruction-fetch front end with a small prefetch queue. It issues sequential fetch requests to an instruction memory that has variable latency and a valid/ready handshake. Returned instructions are buffered and presented to the IF/ID pipeline register as {pc, instruction, pc_plus_4} under a valid/ready handshake. It absorbs hazard stalls through backpressure and flushes on branch/jump redirects from EX, discarding stale in-flight responses.

---
 rtl/if_prefetch_unit_pkg.sv | 17 +
 rtl/if_prefetch_unit_fetch_fifo.sv | 53 +++++
 rtl/if_prefetch_unit.sv | 102 ++++++++++
 tb/tb_if_prefetch_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/if_prefetch_unit_pkg.sv
// Shared constants and payload types for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries; clear overrides push/pop.
module if_prefetch_unit_fetch_fifo
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic                           i_clear,
    input  fetch_entry_t                   i_push_data,
    output logic [$clog2(DEPTH):0]         o_count,
    output fetch_entry_t                   o_head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    // Storage is reset too so the head reads as zero while the queue is empty after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response
// buffering, and redirect flush that drops every response still in flight.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instruction,
    output logic [XLEN-1:0] out_pc_plus_4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_data;
    logic            w_credit_ok;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_pop;
    logic            w_push;
    logic [CW-1:0]   w_inflight_next;
    logic [XLEN-1:0] w_redirect_pc;

    // Queued plus outstanding never exceeds DEPTH, so a response always has a slot.
    assign w_credit_ok     = (SW'(w_count) + SW'(r_inflight)) < SW'(DEPTH);
    assign imem_req_valid  = rst & w_credit_ok;
    assign imem_req_addr   = r_fetch_pc;

    assign w_req_fire      = imem_req_valid & imem_req_ready;
    assign w_rsp_fire      = imem_rsp_valid;
    assign w_pop           = out_valid & out_ready;
    assign w_push          = w_rsp_fire & (r_drop == '0) & ~redirect_valid;
    assign w_inflight_next = r_inflight + CW'(w_req_fire) - CW'(w_rsp_fire);
    assign w_redirect_pc   = align_word(redirect_pc);
    assign w_push_data     = '{pc: r_rsp_pc, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            r_inflight <= w_inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old stream.
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
                r_drop     <= w_inflight_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(INSTR_BYTES);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(INSTR_BYTES);
                end
                if (w_rsp_fire && (r_drop != '0)) begin
                    r_drop <= r_drop - CW'(1);
                end
            end
        end
    end

    if_prefetch_unit_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (redirect_valid),
        .i_push_data (w_push_data),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign out_valid       = (w_count != '0);
    assign out_pc          = w_head.pc;
    assign out_instruction = w_head.instr;
    assign out_pc_plus_4   = out_valid ? (w_head.pc + XLEN'(INSTR_BYTES)) : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized bench for if_prefetch_unit: epoch-tagged memory model plus an
// expected-output queue of PCs, checked every cycle.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic [31:0] out_pc_plus_4;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_out_valid;
    logic [31:0] w_out_pc;
    logic [31:0] w_out_instr;
    logic [31:0] w_out_pc4;

    always #5 clk = ~clk;

    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_pc_plus_4   (out_pc_plus_4)
    );

    // Second instance only exercises a reset PC at the top of the address space.
    if_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (1'b0),
        .redirect_pc     (32'h0),
        .imem_req_valid  (w_req_valid),
        .imem_req_ready  (1'b1),
        .imem_req_addr   (w_req_addr),
        .imem_rsp_valid  (1'b0),
        .imem_rsp_data   (32'h0),
        .out_valid       (w_out_valid),
        .out_ready       (1'b0),
        .out_pc          (w_out_pc),
        .out_instruction (w_out_instr),
        .out_pc_plus_4   (w_out_pc4)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mem_req_t;

    mem_req_t    pend[$];
    logic [31:0] mq[$];
    int unsigned epoch = 0;
    int unsigned cyc = 0;
    int unsigned last_due = 0;
    logic [31:0] exp_fetch = 32'h0;
    int          n_checks = 0;
    int          n_fails = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("rst_out_pc", out_pc, 32'd0);
        check_val("rst_out_instr", out_instruction, 32'd0);
        check_val("rst_out_pc4", out_pc_plus_4, 32'd0);
        check_val("rst_wrap_req_valid", 32'(w_req_valid), 32'd0);
        pend.delete();
        mq.delete();
        epoch     = 0;
        exp_fetch = 32'h0;
        last_due  = cyc;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("wrap_first_valid", 32'(w_req_valid), 32'd1);
        check_val("wrap_first_addr", w_req_addr, 32'hFFFF_FFFC);
        check_val("wrap_head_zero", w_out_pc | w_out_instr | w_out_pc4, 32'd0);
        @(negedge clk);
        #1;
        check_val("wrap_second_addr", w_req_addr, 32'h0000_0000);
        check_val("wrap_out_valid", 32'(w_out_valid), 32'd0);
    endtask

    task automatic step(input int unsigned p_redir, input int unsigned p_rdy,
                        input int unsigned p_ordy, input int unsigned lat_max);
        logic        rsp_now;
        logic        req_fire;
        logic        pop;
        logic [31:0] tgt;
        logic [31:0] head;
        int unsigned stale;
        int unsigned due;
        mem_req_t    r;

        @(negedge clk);
        cyc++;
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        else                        tgt = $urandom & 32'h0000_FFFF;
        redirect_valid = ($urandom_range(99) < p_redir);
        redirect_pc    = tgt;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        out_ready      = ($urandom_range(99) < p_ordy);
        rsp_now        = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? (pend[0].addr ^ MAGIC) : $urandom;
        #1;

        check_val("req_valid", 32'(imem_req_valid), 32'(mq.size() + pend.size() < DEPTH));
        if (imem_req_valid) check_val("req_addr", imem_req_addr, exp_fetch);
        check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            check_val("out_pc", out_pc, head);
            check_val("out_instr", out_instruction, head ^ MAGIC);
            check_val("out_pc4", out_pc_plus_4, head + 32'd4);
        end
        stale = 0;
        foreach (pend[i]) if (pend[i].epoch != epoch) stale++;
        check_val("inflight", 32'(dut.r_inflight), 32'(pend.size()));
        check_val("drop", 32'(dut.r_drop), 32'(stale));
        check_val("inflight_le_depth", 32'(dut.r_inflight <= 3'(DEPTH)), 32'd1);
        check_val("drop_le_inflight", 32'(dut.r_drop <= dut.r_inflight), 32'd1);

        req_fire = imem_req_valid & imem_req_ready;
        pop      = out_valid & out_ready;
        if (pop) void'(mq.pop_front());
        if (rsp_now) begin
            r = pend.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                check_val("push_not_full", 32'(mq.size() < DEPTH), 32'd1);
                mq.push_back(r.addr);
            end
        end
        if (req_fire) begin
            due = cyc + 32'($urandom_range(lat_max, 1));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{addr: exp_fetch, epoch: epoch, due: due});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (redirect_valid) begin
            mq.delete();
            epoch++;
            exp_fetch = tgt & 32'hFFFF_FFFC;
        end
    endtask

    initial begin
        apply_reset();
        repeat (40)   step(0, 100, 100, 1);
        repeat (10)   step(0, 100, 0, 1);
        repeat (30)   step(0, 100, 100, 1);
        repeat (300)  step(10, 70, 70, 3);
        repeat (5)    step(0, 0, 100, 2);
        repeat (20)   step(0, 100, 100, 2);
        repeat (1500) step(5, 60, 60, DEPTH + 2);
        repeat (8)    step(0, 100, 0, 2);
        apply_reset();
        repeat (200)  step(8, 80, 80, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
